// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit ripple adder resolved SEG bits per register stage, valid/ready backpressure; PRA_OVERFLOW_EN adds a signed overflow output
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SEG = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef PRA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);
    localparam int STAGES = WIDTH / SEG;
    logic adv;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : st
            logic v_i, c_i, v_q, c_q;
            logic [WIDTH-1:k*SEG] a_i, b_i;
            logic [SEG:0] seg;
            logic [(k+1)*SEG-1:0] s_n, s_q;
            if (k == 0) begin : src
                assign v_i = in_valid && in_ready;
                assign c_i = carry_in;
                assign a_i = a;
                assign b_i = b;
                assign s_n = seg[SEG-1:0];
            end else begin : src
                assign v_i = st[k-1].v_q;
                assign c_i = st[k-1].c_q;
                assign a_i = st[k-1].fwd.a_q;
                assign b_i = st[k-1].fwd.b_q;
                assign s_n = {seg[SEG-1:0], st[k-1].s_q};
            end
            assign seg = {1'b0, a_i[k*SEG +: SEG]} + {1'b0, b_i[k*SEG +: SEG]} + {{SEG{1'b0}}, c_i};
            // Resolve this segment and append it to the already-resolved low bits
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (adv) begin
                    v_q <= v_i;
                    c_q <= seg[SEG];
                    s_q <= s_n;
                end
            end
            if (k < STAGES - 1) begin : fwd
                logic [WIDTH-1:(k+1)*SEG] a_q, b_q;
                // Carry the still-unresolved upper operand bits to the next stage
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (adv) begin
                        a_q <= a_i[WIDTH-1:(k+1)*SEG];
                        b_q <= b_i[WIDTH-1:(k+1)*SEG];
                    end
                end
            end
        end
    endgenerate
    assign out_valid = st[STAGES-1].v_q;
    assign carry_out = st[STAGES-1].c_q;
    assign sum = st[STAGES-1].s_q;
`ifdef PRA_OVERFLOW_EN
    logic ovf_q;
    // Signed overflow from the operand MSBs that reach the last stage, aligned with sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else if (adv) ovf_q <= (st[STAGES-1].a_i[WIDTH-1] == st[STAGES-1].b_i[WIDTH-1]) &&
                               (st[STAGES-1].seg[SEG-1] != st[STAGES-1].a_i[WIDTH-1]);
    end
    assign overflow = ovf_q;
`endif
endmodule
